// File: rtl/pll_mgmt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pll_mgmt_pkg
//  Description : Register indices, write-data field positions and FSM state
//                encoding shared by the PLL management responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pll_mgmt_pkg;

    // Register indices on the management port
    localparam logic [5:0] PLLR_MODE   = 6'd0;
    localparam logic [5:0] PLLR_STATUS = 6'd1;
    localparam logic [5:0] PLLR_APPLY  = 6'd2;
    localparam logic [5:0] PLLR_N      = 6'd3;
    localparam logic [5:0] PLLR_M      = 6'd4;
    localparam logic [5:0] PLLR_C      = 6'd5;
    localparam logic [5:0] PLLR_PHASE  = 6'd6;
    localparam logic [5:0] PLLR_K      = 6'd7;
    localparam logic [5:0] PLLR_BW     = 6'd8;
    localparam logic [5:0] PLLR_CP     = 6'd9;

    // C-counter write: [22:18] counter select, [17:0] counter word
    localparam int c_CSEL_LSB = 18;
    localparam int c_CSEL_MSB = 22;
    localparam int c_CVAL_MSB = 17;

    // Phase write: [15:0] steps, [20:16] counter select, [21] direction
    localparam int c_PSTEP_MSB = 15;
    localparam int c_PSEL_LSB  = 16;
    localparam int c_PSEL_MSB  = 20;
    localparam int c_PDIR_BIT  = 21;

    // Counter select codes
    localparam logic [4:0] c_SEL_C0 = 5'd0;
    localparam logic [4:0] c_SEL_C1 = 5'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        PHASE = 2'd2
    } pll_mgmt_state_t;

endpackage : pll_mgmt_pkg
`default_nettype wire

// File: rtl/pll_lock_model.sv
`default_nettype none
// ============================================================================
//  Module      : pll_lock_model
//  Description : Models PLL lock acquisition: locked rises LOCK_CYCLES clocks
//                after pll_rst and clr are both low; either one drops it.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_model #(
    parameter int LOCK_CYCLES = 200
) (
    input  logic CLK_50M,
    input  logic RESET,
    input  logic pll_rst,
    input  logic clr,
    output logic locked
);

    localparam int                c_CW   = $clog2(LOCK_CYCLES + 1);
    localparam logic [c_CW-1:0]   c_LAST = c_CW'(LOCK_CYCLES - 1);

    logic [c_CW-1:0] r_count;
    logic            r_locked;

    // Count lock-acquisition time; any reset source restarts it from zero
    always_ff @(posedge CLK_50M) begin
        if (RESET || pll_rst || clr) begin
            r_count  <= '0;
            r_locked <= 1'b0;
        end else if (!r_locked) begin
            if (r_count == c_LAST) begin
                r_locked <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign locked = r_locked;

endmodule : pll_lock_model
`default_nettype wire

// File: rtl/pll_mgmt_responder.sv
`default_nettype none
// ============================================================================
//  Module      : pll_mgmt_responder
//  Description : Avalon-MM stand-in for the PLL reconfig management port.
//                Holds shadow settings, commits them on Apply, steps the C1
//                phase, and models busy time and lock loss.
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_mgmt_responder
    import pll_mgmt_pkg::*;
#(
    parameter int APPLY_CYCLES      = 64,
    parameter int PHASE_STEP_CYCLES = 4,
    parameter int LOCK_CYCLES       = 200
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        mgmt_write,
    input  logic        mgmt_read,
    input  logic [5:0]  mgmt_address,
    input  logic [31:0] mgmt_writedata,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    input  logic        pll_rst,
    output logic        locked,
    output logic [17:0] cfg_m,
    output logic [17:0] cfg_n,
    output logic [17:0] cfg_c0,
    output logic [17:0] cfg_c1,
    output logic [31:0] cfg_k,
    output logic [3:0]  cfg_cp,
    output logic [3:0]  cfg_bw,
    output logic [15:0] phase_pos,
    output logic [15:0] apply_count
);

    localparam int c_MAX_CYC = (APPLY_CYCLES > PHASE_STEP_CYCLES) ? APPLY_CYCLES
                                                                  : PHASE_STEP_CYCLES;
    localparam int                 c_CNT_W      = $clog2(c_MAX_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_APPLY_LAST = c_CNT_W'(APPLY_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_PHASE_LAST = c_CNT_W'(PHASE_STEP_CYCLES - 1);

    pll_mgmt_state_t     r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_waitreq;

    // Shadow (uncommitted) settings
    logic [17:0] r_sh_n;
    logic [17:0] r_sh_m;
    logic [17:0] r_sh_c0;
    logic [17:0] r_sh_c1;
    logic [31:0] r_sh_k;
    logic [3:0]  r_sh_bw;
    logic [3:0]  r_sh_cp;

    // Pending work
    logic        r_pend_cfg;
    logic        r_pend_phase;
    logic [15:0] r_pend_steps;
    logic        r_phase_dir;

    // Committed settings
    logic [17:0] r_cfg_m;
    logic [17:0] r_cfg_n;
    logic [17:0] r_cfg_c0;
    logic [17:0] r_cfg_c1;
    logic [31:0] r_cfg_k;
    logic [3:0]  r_cfg_cp;
    logic [3:0]  r_cfg_bw;
    logic [15:0] r_phase_pos;
    logic [15:0] r_apply_count;
    logic [31:0] r_readdata;

    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_busy;
    logic        w_apply_wr;
    logic        w_apply_cfg;
    logic [4:0]  w_csel;
    logic [4:0]  w_psel;
    logic        w_c_hit;
    logic        w_p_hit;
    logic [31:0] w_rd_mux;

    // A strobe is only taken while the responder is not stalling
    assign w_busy      = (r_state != IDLE);
    assign w_wr_acc    = mgmt_write && !r_waitreq;
    assign w_rd_acc    = mgmt_read  && !r_waitreq;
    assign w_apply_wr  = w_wr_acc && (mgmt_address == PLLR_APPLY) && (r_state == IDLE);
    assign w_apply_cfg = w_apply_wr && r_pend_cfg;

    assign w_csel  = mgmt_writedata[c_CSEL_MSB:c_CSEL_LSB];
    assign w_psel  = mgmt_writedata[c_PSEL_MSB:c_PSEL_LSB];
    assign w_c_hit = (w_csel == c_SEL_C0) || (w_csel == c_SEL_C1);
    assign w_p_hit = (w_psel == c_SEL_C1);

    // Capture shadow settings from accepted writes
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_sh_n  <= '0;
            r_sh_m  <= '0;
            r_sh_c0 <= '0;
            r_sh_c1 <= '0;
            r_sh_k  <= '0;
            r_sh_bw <= '0;
            r_sh_cp <= '0;
        end else if (w_wr_acc) begin
            case (mgmt_address)
                PLLR_N:  r_sh_n  <= mgmt_writedata[17:0];
                PLLR_M:  r_sh_m  <= mgmt_writedata[17:0];
                PLLR_K:  r_sh_k  <= mgmt_writedata;
                PLLR_BW: r_sh_bw <= mgmt_writedata[3:0];
                PLLR_CP: r_sh_cp <= mgmt_writedata[3:0];
                PLLR_C: begin
                    if (w_csel == c_SEL_C0) r_sh_c0 <= mgmt_writedata[c_CVAL_MSB:0];
                    if (w_csel == c_SEL_C1) r_sh_c1 <= mgmt_writedata[c_CVAL_MSB:0];
                end
                default: ;
            endcase
        end
    end

    // Read-data selection from the state seen before this cycle's write
    always_comb begin
        w_rd_mux = '0;
        case (mgmt_address)
            PLLR_STATUS: w_rd_mux = {31'b0, !w_busy};
            PLLR_N:      w_rd_mux = {14'b0, r_sh_n};
            PLLR_M:      w_rd_mux = {14'b0, r_sh_m};
            PLLR_C:      w_rd_mux = {14'b0, r_sh_c0};
            PLLR_PHASE:  w_rd_mux = {16'b0, r_pend_steps};
            PLLR_K:      w_rd_mux = r_sh_k;
            PLLR_BW:     w_rd_mux = {28'b0, r_sh_bw};
            PLLR_CP:     w_rd_mux = {28'b0, r_sh_cp};
            default:     w_rd_mux = '0;
        endcase
    end

    // Register read data on each accepted read; hold it otherwise
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_readdata <= '0;
        end else if (w_rd_acc) begin
            r_readdata <= w_rd_mux;
        end
    end

    // Apply/phase sequencer together with the pending flags it consumes
    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_waitreq     <= 1'b0;
            r_pend_cfg    <= 1'b0;
            r_pend_phase  <= 1'b0;
            r_pend_steps  <= '0;
            r_phase_dir   <= 1'b0;
            r_cfg_m       <= '0;
            r_cfg_n       <= '0;
            r_cfg_c0      <= '0;
            r_cfg_c1      <= '0;
            r_cfg_k       <= '0;
            r_cfg_cp      <= '0;
            r_cfg_bw      <= '0;
            r_phase_pos   <= '0;
            r_apply_count <= '0;
        end else begin
            // Settings writes can only land while idle, so they never race the FSM
            if (w_wr_acc) begin
                case (mgmt_address)
                    PLLR_N, PLLR_M, PLLR_K, PLLR_BW, PLLR_CP: r_pend_cfg <= 1'b1;
                    PLLR_C: begin
                        if (w_c_hit) r_pend_cfg <= 1'b1;
                    end
                    PLLR_PHASE: begin
                        if (w_p_hit) begin
                            r_pend_steps <= r_pend_steps + mgmt_writedata[c_PSTEP_MSB:0];
                            r_phase_dir  <= mgmt_writedata[c_PDIR_BIT];
                            r_pend_phase <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            case (r_state)
                IDLE: begin
                    if (w_apply_cfg) begin
                        r_state       <= APPLY;
                        r_waitreq     <= 1'b1;
                        r_cnt         <= '0;
                        r_pend_cfg    <= 1'b0;
                        r_cfg_m       <= r_sh_m;
                        r_cfg_n       <= r_sh_n;
                        r_cfg_c0      <= r_sh_c0;
                        r_cfg_c1      <= r_sh_c1;
                        r_cfg_k       <= r_sh_k;
                        r_cfg_cp      <= r_sh_cp;
                        r_cfg_bw      <= r_sh_bw;
                        r_apply_count <= r_apply_count + 1'b1;
                    end else if (w_apply_wr && r_pend_phase) begin
                        // A zero-step request completes without any busy time
                        if (r_pend_steps != '0) begin
                            r_state   <= PHASE;
                            r_waitreq <= 1'b1;
                            r_cnt     <= '0;
                        end else begin
                            r_pend_phase <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    if (r_cnt == c_APPLY_LAST) begin
                        r_cnt <= '0;
                        if (r_pend_phase && (r_pend_steps != '0)) begin
                            r_state <= PHASE;
                        end else begin
                            r_state      <= IDLE;
                            r_waitreq    <= 1'b0;
                            r_pend_phase <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PHASE: begin
                    if (r_cnt == c_PHASE_LAST) begin
                        r_cnt        <= '0;
                        r_phase_pos  <= r_phase_dir ? (r_phase_pos + 16'd1)
                                                    : (r_phase_pos - 16'd1);
                        r_pend_steps <= r_pend_steps - 16'd1;
                        if (r_pend_steps == 16'd1) begin
                            r_pend_phase <= 1'b0;
                            r_state      <= IDLE;
                            r_waitreq    <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_waitreq <= 1'b0;
                end
            endcase
        end
    end

    // Lock drops when the PLL is reset or a new configuration is committed
    pll_lock_model #(
        .LOCK_CYCLES (LOCK_CYCLES)
    ) u_lock (
        .CLK_50M (CLK_50M),
        .RESET   (RESET),
        .pll_rst (pll_rst),
        .clr     (w_apply_cfg),
        .locked  (locked)
    );

    assign mgmt_readdata    = r_readdata;
    assign mgmt_waitrequest = r_waitreq;
    assign cfg_m            = r_cfg_m;
    assign cfg_n            = r_cfg_n;
    assign cfg_c0           = r_cfg_c0;
    assign cfg_c1           = r_cfg_c1;
    assign cfg_k            = r_cfg_k;
    assign cfg_cp           = r_cfg_cp;
    assign cfg_bw           = r_cfg_bw;
    assign phase_pos        = r_phase_pos;
    assign apply_count      = r_apply_count;

endmodule : pll_mgmt_responder
`default_nettype wire

// File: tb/tb_pll_mgmt_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_mgmt_responder
//  Description : Directed self-checking bench for pll_mgmt_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_mgmt_responder;

    logic        CLK_50M        = 1'b0;
    logic        RESET          = 1'b1;
    logic        mgmt_write     = 1'b0;
    logic        mgmt_read      = 1'b0;
    logic [5:0]  mgmt_address   = '0;
    logic [31:0] mgmt_writedata = '0;
    logic        pll_rst        = 1'b0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic        locked;
    logic [17:0] cfg_m, cfg_n, cfg_c0, cfg_c1;
    logic [31:0] cfg_k;
    logic [3:0]  cfg_cp, cfg_bw;
    logic [15:0] phase_pos;
    logic [15:0] apply_count;

    int errors = 0;
    int checks = 0;

    pll_mgmt_responder #(
        .APPLY_CYCLES      (64),
        .PHASE_STEP_CYCLES (4),
        .LOCK_CYCLES       (200)
    ) dut (
        .CLK_50M          (CLK_50M),
        .RESET            (RESET),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_address     (mgmt_address),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_rst          (pll_rst),
        .locked           (locked),
        .cfg_m            (cfg_m),
        .cfg_n            (cfg_n),
        .cfg_c0           (cfg_c0),
        .cfg_c1           (cfg_c1),
        .cfg_k            (cfg_k),
        .cfg_cp           (cfg_cp),
        .cfg_bw           (cfg_bw),
        .phase_pos        (phase_pos),
        .apply_count      (apply_count)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_50M);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (mgmt_waitrequest && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) check("idle_timeout", {31'b0, mgmt_waitrequest}, 32'd0);
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        wait_idle();
        mgmt_address   = addr;
        mgmt_writedata = data;
        mgmt_write     = 1'b1;
        tick();
        mgmt_write     = 1'b0;
    endtask

    task automatic rd(input logic [5:0] addr, output logic [31:0] data);
        wait_idle();
        mgmt_address = addr;
        mgmt_read    = 1'b1;
        tick();
        mgmt_read    = 1'b0;
        data         = mgmt_readdata;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (mgmt_waitrequest && n < 5000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        logic [31:0] d;
        int          n;

        // Reset state
        repeat (3) tick();
        check("rst_readdata", mgmt_readdata, 32'd0);
        check("rst_waitreq",  {31'b0, mgmt_waitrequest}, 32'd0);
        check("rst_locked",   {31'b0, locked}, 32'd0);
        check("rst_cfg_m",    {14'b0, cfg_m}, 32'd0);
        check("rst_cfg_k",    cfg_k, 32'd0);
        check("rst_phase",    {16'b0, phase_pos}, 32'd0);
        check("rst_applycnt", {16'b0, apply_count}, 32'd0);

        // Lock acquisition: 200 edges after reset release
        RESET = 1'b0;
        repeat (199) tick();
        check("lock_199", {31'b0, locked}, 32'd0);
        tick();
        check("lock_200", {31'b0, locked}, 32'd1);

        rd(6'd1, d);  check("status_idle", d, 32'd1);
        rd(6'd12, d); check("unmapped_rd", d, 32'd0);
        wr(6'd0, 32'hFFFF_FFFF);
        rd(6'd0, d);  check("mode_rd", d, 32'd0);

        // Config commit
        wr(6'd4, 32'h0000_0808);
        wr(6'd7, 32'hB333_32DD);
        wr(6'd5, 32'h0002_0302);
        wr(6'd5, 32'h0006_0302);
        rd(6'd4, d);  check("shadow_m", d, 32'h0000_0808);
        rd(6'd7, d);  check("shadow_k", d, 32'hB333_32DD);
        wr(6'd2, 32'd0);
        busy_len(n);
        check("apply_busy", n, 32'd64);
        check("cfg_m",   {14'b0, cfg_m},  32'h0000_0808);
        check("cfg_c0",  {14'b0, cfg_c0}, 32'h0002_0302);
        check("cfg_c1",  {14'b0, cfg_c1}, 32'h0002_0302);
        check("cfg_k",   cfg_k, 32'hB333_32DD);
        check("applycnt_1", {16'b0, apply_count}, 32'd1);

        // Phase down by 29
        wr(6'd6, 32'h0001_001D);
        rd(6'd6, d);  check("pend_steps", d, 32'd29);
        wr(6'd2, 32'd0);
        repeat (3) tick();
        check("phase_pre_step", {16'b0, phase_pos}, 32'd0);
        tick();
        check("phase_first_step", {16'b0, phase_pos}, 32'h0000_FFFF);
        busy_len(n);
        check("phase_dn_busy", n + 4, 32'd116);
        check("phase_dn_pos", {16'b0, phase_pos}, 32'h0000_FFE3);
        check("applycnt_still1", {16'b0, apply_count}, 32'd1);

        // Phase up by 29
        wr(6'd6, 32'h0021_001D);
        wr(6'd2, 32'd0);
        busy_len(n);
        check("phase_up_busy", n, 32'd116);
        check("phase_up_pos", {16'b0, phase_pos}, 32'd0);

        // Simultaneous write and read return the pre-write value
        wait_idle();
        mgmt_address   = 6'd3;
        mgmt_writedata = 32'h0000_0123;
        mgmt_write     = 1'b1;
        mgmt_read      = 1'b1;
        tick();
        mgmt_write     = 1'b0;
        mgmt_read      = 1'b0;
        check("rw_same_cycle", mgmt_readdata, 32'd0);
        rd(6'd3, d);  check("shadow_n", d, 32'h0000_0123);

        // Config plus phase in a single Apply
        wr(6'd9, 32'd5);
        wr(6'd8, 32'd3);
        wr(6'd6, 32'h0001_0003);
        check("locked_before", {31'b0, locked}, 32'd1);
        wr(6'd2, 32'd0);
        check("locked_in_apply", {31'b0, locked}, 32'd0);
        busy_len(n);
        check("cfg_phase_busy", n, 32'd76);
        check("cfg_n",  {14'b0, cfg_n}, 32'h0000_0123);
        check("cfg_cp", {28'b0, cfg_cp}, 32'd5);
        check("cfg_bw", {28'b0, cfg_bw}, 32'd3);
        check("applycnt_2", {16'b0, apply_count}, 32'd2);
        check("phase_pos_3", {16'b0, phase_pos}, 32'h0000_FFFD);

        // Zero-step phase request
        wr(6'd6, 32'h0001_0000);
        wr(6'd2, 32'd0);
        check("zero_step_busy", {31'b0, mgmt_waitrequest}, 32'd0);
        check("zero_step_pos", {16'b0, phase_pos}, 32'h0000_FFFD);

        // Reset in the middle of APPLY
        wr(6'd4, 32'h0000_1234);
        wr(6'd6, 32'h0001_0002);
        wr(6'd2, 32'd0);
        repeat (30) tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("mid_rst_waitreq", {31'b0, mgmt_waitrequest}, 32'd0);
        check("mid_rst_cfg_m",   {14'b0, cfg_m}, 32'd0);
        check("mid_rst_cfg_n",   {14'b0, cfg_n}, 32'd0);
        check("mid_rst_applycnt", {16'b0, apply_count}, 32'd0);
        check("mid_rst_phase",   {16'b0, phase_pos}, 32'd0);
        check("mid_rst_locked",  {31'b0, locked}, 32'd0);
        check("mid_rst_rdata",   mgmt_readdata, 32'd0);
        wr(6'd2, 32'd0);
        check("post_rst_apply", {31'b0, mgmt_waitrequest}, 32'd0);
        rd(6'd4, d);  check("post_rst_shadow_m", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pll_mgmt_responder
`default_nettype wire
